uart_tx_serializer: RTL

- UART transmit serializer, directly downstream of the baud-rate clock divider.
- Consumes the divider's one-cycle baud tick and a byte-wide valid/ready data interface.
- Drives the serial TX line with an LSB-first frame: start bit, data bits, optional parity, stop bit(s).
- Every bit, including the start bit, lasts exactly one baud-tick period.

---
 rtl/uart_tx_serializer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: LSB-first frame of start, data, optional parity and stop bits, paced by BAUD_TICK.
// Optional parity bit is compiled in when the macro UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 BAUD_TICK,
    input  logic [DATA_BITS-1:0] TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic                 TX,
    output logic                 BUSY,
    output logic                 TX_DONE
);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("DATA_BITS must be in 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("PARITY_ODD must be 0 or 1");
    end

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TICK, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TICK, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t               state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 tx_done_q, tx_done_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        tx_done_d  = 1'b0;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (TX_VALID) begin
                    shift_d = TX_DATA;
                    busy_d  = 1'b1;
                    state_d = S_WAIT_TICK;
`ifdef UART_TX_PARITY_EN
                    // Parity captured from the accepted byte; the shifter destroys it later.
                    parity_d = (^TX_DATA) ^ (PARITY_ODD != 0);
`endif
                end
            end
            // A tick coinciding with acceptance is not seen here, so the start bit is a full period.
            S_WAIT_TICK: begin
                if (BAUD_TICK) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (BAUD_TICK) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (BAUD_TICK) begin
                    if (bit_idx_q < LAST_BIT) begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (BAUD_TICK) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (BAUD_TICK) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d    = S_IDLE;
                        busy_d     = 1'b0;
                        tx_done_d  = 1'b1;
                        stop_cnt_d = 1'b0;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
            shift_q    <= '0;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign TX_READY = (state_q == S_IDLE);
    assign TX       = tx_q;
    assign BUSY     = busy_q;
    assign TX_DONE  = tx_done_q;

endmodule
